// File: rtl/frame_router_pkg.sv
// Shared types and widths for the frame router and its per-direction frame tracker.
package frame_router_pkg;
  localparam int RX_BYTE_W = 8;
  localparam int BITS_W    = 3;

  typedef enum logic {RX_IDLE  = 1'b0, RX_FRAME  = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE  = 1'b0, TX_FRAME  = 1'b1} tx_state_t;
  typedef enum logic {TRK_IDLE = 1'b0, TRK_FRAME = 1'b1} trk_state_t;
endpackage

// File: rtl/frame_router_frame_tracker.sv
// Two-state frame tracker: latches a route select on frame start, holds it until frame end.
//   state     | meaning
//   TRK_IDLE  | between frames, consumer uses the live route
//   TRK_FRAME | inside a frame, consumer uses the latched sel_q
module frame_tracker
  import frame_router_pkg::*;
#(
  parameter int SEL_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [SEL_W-1:0] sel_in,
  output logic             in_frame,
  output logic [SEL_W-1:0] sel_q
);

  trk_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRK_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // A start seen while already in a frame re-latches; stop wins over start.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      TRK_IDLE: begin
        if (start) begin
          sel_d   = sel_in;
          state_d = TRK_FRAME;
        end
      end
      TRK_FRAME: begin
        if (start) sel_d = sel_in;
      end
      default: state_d = TRK_IDLE;
    endcase
    if (stop) state_d = TRK_IDLE;
  end

  assign in_frame = (state_q == TRK_FRAME);

endmodule

// File: rtl/frame_router.sv
// Frame-aware Rx fan-out / Tx mux; route selections only change at frame boundaries.
module frame_router
  import frame_router_pkg::*;
#(
  parameter int NUM_RX_DESTS = 2,
  parameter int NUM_TX_SRCS  = 2,
  parameter int TX_SEL_W     = (NUM_TX_SRCS > 1) ? $clog2(NUM_TX_SRCS) : 1,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RX_DESTS-1:0]           rx_route,
  input  logic [TX_SEL_W-1:0]               tx_route,
  input  logic [RX_BYTE_W-1:0]              in_rx_data,
  input  logic [BITS_W-1:0]                 in_rx_data_bits,
  input  logic                              in_rx_soc,
  input  logic                              in_rx_eoc,
  input  logic                              in_rx_data_valid,
  input  logic                              in_rx_error,
  output logic [RX_BYTE_W-1:0]              out_rx_data,
  output logic [BITS_W-1:0]                 out_rx_data_bits,
  output logic [NUM_RX_DESTS-1:0]           out_rx_soc,
  output logic [NUM_RX_DESTS-1:0]           out_rx_eoc,
  output logic [NUM_RX_DESTS-1:0]           out_rx_data_valid,
  output logic [NUM_RX_DESTS-1:0]           out_rx_error,
  input  logic [NUM_TX_SRCS*RX_BYTE_W-1:0]  in_tx_data,
  input  logic [NUM_TX_SRCS*BITS_W-1:0]     in_tx_data_bits,
  input  logic [NUM_TX_SRCS-1:0]            in_tx_data_valid,
  input  logic [NUM_TX_SRCS-1:0]            in_tx_append_crc,
  output logic [NUM_TX_SRCS-1:0]            in_tx_req,
  output logic [RX_BYTE_W-1:0]              out_tx_data,
  output logic [BITS_W-1:0]                 out_tx_data_bits,
  output logic                              out_tx_data_valid,
  output logic                              out_tx_append_crc,
  input  logic                              out_tx_req,
  output logic [DROP_CNT_W-1:0]             rx_dropped_frames,
  output logic                              tx_route_pending
);

  rx_state_t                rx_state;
  tx_state_t                tx_state;
  logic                     rx_in_frame, tx_in_frame;
  logic [NUM_RX_DESTS-1:0]  rx_sel_q, rx_eff;
  logic [TX_SEL_W-1:0]      tx_sel_q, tx_eff;
  logic                     tx_start, tx_stop;
  logic [DROP_CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  frame_tracker #(.SEL_W(NUM_RX_DESTS)) u_rx_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (in_rx_soc),
    .stop     (in_rx_eoc),
    .sel_in   (rx_route),
    .in_frame (rx_in_frame),
    .sel_q    (rx_sel_q)
  );

  assign rx_state = rx_state_t'(rx_in_frame);
  assign rx_eff   = (rx_state == RX_FRAME) ? rx_sel_q : rx_route;

  assign out_rx_data       = in_rx_data;
  assign out_rx_data_bits  = in_rx_data_bits;
  assign out_rx_soc        = {NUM_RX_DESTS{in_rx_soc}}        & rx_eff;
  assign out_rx_eoc        = {NUM_RX_DESTS{in_rx_eoc}}        & rx_eff;
  assign out_rx_data_valid = {NUM_RX_DESTS{in_rx_data_valid}} & rx_eff;
  assign out_rx_error      = {NUM_RX_DESTS{in_rx_error}}      & rx_eff;

  // A frame starting with an all-zero route is dropped; count saturates.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_rx_soc && (rx_route == '0) && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign rx_dropped_frames = drop_cnt_q;

  assign tx_state = tx_state_t'(tx_in_frame);
  assign tx_eff   = (tx_state == TX_FRAME) ? tx_sel_q : tx_route;

  // Out-of-range source indices match no entry, leaving everything at zero.
  always_comb begin
    out_tx_data       = '0;
    out_tx_data_bits  = '0;
    out_tx_data_valid = 1'b0;
    out_tx_append_crc = 1'b0;
    in_tx_req         = '0;
    for (int s = 0; s < NUM_TX_SRCS; s++) begin
      if (tx_eff == TX_SEL_W'(s)) begin
        out_tx_data       = in_tx_data[s*RX_BYTE_W +: RX_BYTE_W];
        out_tx_data_bits  = in_tx_data_bits[s*BITS_W +: BITS_W];
        out_tx_data_valid = in_tx_data_valid[s];
        out_tx_append_crc = in_tx_append_crc[s];
        in_tx_req[s]      = out_tx_req;
      end
    end
  end

  assign tx_start = (tx_state == TX_IDLE)  &&  out_tx_data_valid;
  assign tx_stop  = (tx_state == TX_FRAME) && !out_tx_data_valid;

  frame_tracker #(.SEL_W(TX_SEL_W)) u_tx_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tx_start),
    .stop     (tx_stop),
    .sel_in   (tx_route),
    .in_frame (tx_in_frame),
    .sel_q    (tx_sel_q)
  );

  assign tx_route_pending = (tx_state == TX_FRAME) && (tx_route != tx_sel_q);

endmodule

// File: tb/tb_frame_router.sv
// Randomized and directed bench for frame_router against a transaction-level reference model.
module tb_frame_router;
  localparam int NR   = 2;
  localparam int NT   = 2;
  localparam int SW   = 2;
  localparam int DW   = 2;
  localparam int DMAX = (1 << DW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   rx_route = '0;
  logic [SW-1:0]   tx_route = '0;
  logic [7:0]      in_rx_data = '0;
  logic [2:0]      in_rx_data_bits = '0;
  logic            in_rx_soc = 1'b0, in_rx_eoc = 1'b0, in_rx_data_valid = 1'b0, in_rx_error = 1'b0;
  logic [7:0]      out_rx_data;
  logic [2:0]      out_rx_data_bits;
  logic [NR-1:0]   out_rx_soc, out_rx_eoc, out_rx_data_valid, out_rx_error;
  logic [NT*8-1:0] in_tx_data = '0;
  logic [NT*3-1:0] in_tx_data_bits = '0;
  logic [NT-1:0]   in_tx_data_valid = '0, in_tx_append_crc = '0;
  logic [NT-1:0]   in_tx_req;
  logic [7:0]      out_tx_data;
  logic [2:0]      out_tx_data_bits;
  logic            out_tx_data_valid, out_tx_append_crc;
  logic            out_tx_req = 1'b0;
  logic [DW-1:0]   rx_dropped_frames;
  logic            tx_route_pending;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: where the current Rx frame goes, which Tx source owns the current frame.
  bit            m_rx_in;
  logic [NR-1:0] m_rx_dest;
  int            m_drop;
  bit            m_tx_in;
  int            m_tx_src;

  always #5 clk = ~clk;

  frame_router #(
    .NUM_RX_DESTS(NR), .NUM_TX_SRCS(NT), .TX_SEL_W(SW), .DROP_CNT_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_route(rx_route), .tx_route(tx_route),
    .in_rx_data(in_rx_data), .in_rx_data_bits(in_rx_data_bits),
    .in_rx_soc(in_rx_soc), .in_rx_eoc(in_rx_eoc),
    .in_rx_data_valid(in_rx_data_valid), .in_rx_error(in_rx_error),
    .out_rx_data(out_rx_data), .out_rx_data_bits(out_rx_data_bits),
    .out_rx_soc(out_rx_soc), .out_rx_eoc(out_rx_eoc),
    .out_rx_data_valid(out_rx_data_valid), .out_rx_error(out_rx_error),
    .in_tx_data(in_tx_data), .in_tx_data_bits(in_tx_data_bits),
    .in_tx_data_valid(in_tx_data_valid), .in_tx_append_crc(in_tx_append_crc),
    .in_tx_req(in_tx_req), .out_tx_data(out_tx_data), .out_tx_data_bits(out_tx_data_bits),
    .out_tx_data_valid(out_tx_data_valid), .out_tx_append_crc(out_tx_append_crc),
    .out_tx_req(out_tx_req), .rx_dropped_frames(rx_dropped_frames),
    .tx_route_pending(tx_route_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rx_in = 0; m_rx_dest = '0; m_drop = 0; m_tx_in = 0; m_tx_src = 0;
  endtask

  // One cycle: check outputs mid-cycle against the model, advance the model, move past the edge.
  task automatic step();
    logic [NR-1:0] dest;
    int            src;
    logic [7:0]    e_data;
    logic [2:0]    e_bits;
    logic          e_valid, e_crc;
    logic [NT-1:0] e_req;
    #3;
    if (!rst_n) model_reset();
    dest = m_rx_in ? m_rx_dest : rx_route;
    chk("rx_soc",   out_rx_soc,        in_rx_soc        ? dest : '0);
    chk("rx_eoc",   out_rx_eoc,        in_rx_eoc        ? dest : '0);
    chk("rx_valid", out_rx_data_valid, in_rx_data_valid ? dest : '0);
    chk("rx_err",   out_rx_error,      in_rx_error      ? dest : '0);
    chk("rx_data",  out_rx_data,       in_rx_data);
    chk("rx_bits",  out_rx_data_bits,  in_rx_data_bits);
    chk("drop_cnt", rx_dropped_frames, m_drop);
    src = m_tx_in ? m_tx_src : int'(tx_route);
    e_data = '0; e_bits = '0; e_valid = 1'b0; e_crc = 1'b0; e_req = '0;
    if (src < NT) begin
      e_data  = in_tx_data[src*8 +: 8];
      e_bits  = in_tx_data_bits[src*3 +: 3];
      e_valid = in_tx_data_valid[src];
      e_crc   = in_tx_append_crc[src];
      e_req   = out_tx_req ? NT'(1 << src) : '0;
    end
    chk("tx_data",  out_tx_data,       e_data);
    chk("tx_bits",  out_tx_data_bits,  e_bits);
    chk("tx_valid", out_tx_data_valid, e_valid);
    chk("tx_crc",   out_tx_append_crc, e_crc);
    chk("tx_req",   in_tx_req,         e_req);
    chk("tx_pend",  tx_route_pending,  m_tx_in && (int'(tx_route) != m_tx_src));
    if (rst_n) begin
      if (in_rx_soc) begin
        if (rx_route == '0 && m_drop < DMAX) m_drop++;
        m_rx_dest = rx_route;
      end
      if (in_rx_eoc)      m_rx_in = 0;
      else if (in_rx_soc) m_rx_in = 1;
      if (!m_tx_in) begin
        if (src < NT && e_valid) begin m_tx_in = 1; m_tx_src = src; end
      end else if (!e_valid) m_tx_in = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic rx_frame(input int nbytes, input int chg_at, input logic [NR-1:0] new_route);
    in_rx_soc = 1'b1; step(); in_rx_soc = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      if (i == chg_at) rx_route = new_route;
      in_rx_data_valid = 1'b1; in_rx_data = 8'($urandom); in_rx_data_bits = 3'($urandom);
      step();
    end
    in_rx_data_valid = 1'b0; in_rx_eoc = 1'b1; step(); in_rx_eoc = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    step(); step();
    rst_n = 1'b1;

    // Rx unicast, then mid-frame route change, then the next frame on the new route.
    rx_route = 2'b01; rx_frame(3, -1, 2'b01);
    chk("drop_none", rx_dropped_frames, 0);
    rx_frame(3, 1, 2'b10);
    rx_frame(2, -1, 2'b10);

    // Dropped frames and saturation.
    rx_route = 2'b00; rx_frame(1, -1, 2'b00); rx_frame(1, -1, 2'b00);
    chk("drop_two", rx_dropped_frames, 2);
    for (int i = 0; i < 3; i++) rx_frame(1, -1, 2'b00);
    chk("drop_sat", rx_dropped_frames, 3);

    // Tx from source 1 with CRC.
    tx_route = 2'd1; out_tx_req = 1'b1; in_tx_append_crc = 2'b10;
    in_tx_data = 16'hA5_00; in_tx_data_valid = 2'b10; step();
    in_tx_data = 16'h5A_00; step();
    in_tx_data_valid = 2'b00; step();

    // Route change mid Tx frame is held off until the frame ends.
    in_tx_data = 16'h77_3C; in_tx_data_valid = 2'b11; step();
    tx_route = 2'd0; step();
    chk("pend_mid", tx_route_pending, 1);
    chk("hold_src", out_tx_data, 8'h77);
    in_tx_data_valid = 2'b01; step();
    chk("pend_end", tx_route_pending, 0);
    chk("new_src", out_tx_data, 8'h3C);
    in_tx_data_valid = 2'b00; step();

    // Reset mid Rx and Tx frame, then an out-of-range Tx route.
    rx_route = 2'b01; in_rx_soc = 1'b1; in_tx_data_valid = 2'b01; step();
    in_rx_soc = 1'b0; rx_route = 2'b10; tx_route = 2'd1; in_rx_data_valid = 1'b1;
    rst_n = 1'b0; step();
    chk("rst_drop", rx_dropped_frames, 0);
    rst_n = 1'b1; step();
    chk("rst_live", out_rx_data_valid, 2'b10);
    in_rx_data_valid = 1'b0; in_rx_eoc = 1'b1; step(); in_rx_eoc = 1'b0;
    tx_route = 2'd3; in_tx_data_valid = 2'b11; out_tx_req = 1'b1; step();
    chk("oor_req", in_tx_req, 0);
    chk("oor_valid", out_tx_data_valid, 0);
    in_tx_data_valid = 2'b00; step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      rst_n            = ($urandom_range(0, 400) != 0);
      in_rx_soc        = ($urandom_range(0, 7) == 0);
      in_rx_eoc        = ($urandom_range(0, 7) == 0);
      in_rx_data_valid = 1'($urandom);
      in_rx_error      = ($urandom_range(0, 15) == 0);
      in_rx_data       = 8'($urandom);
      in_rx_data_bits  = 3'($urandom);
      if ($urandom_range(0, 9) == 0)  rx_route = NR'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) tx_route = SW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)  in_tx_data_valid = NT'($urandom);
      in_tx_data       = 16'($urandom);
      in_tx_data_bits  = 6'($urandom);
      in_tx_append_crc = NT'($urandom);
      out_tx_req       = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
